// File: rtl/ad_sync_framer_if.sv
// ad_sync_framer_if: video stream bundle between sensor front end and framer.
// Frame/line syncs and raw samples flow in; framed words, sync flag and blanking flow out.
interface ad_sync_framer_if #(
    parameter int ADC_WIDTH   = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 2
);
    logic                              i_vd;
    logic                              i_hd;
    logic [CHANNEL_NUM*ADC_WIDTH-1:0]  iv_pix_data;
    logic [CHANNEL_NUM*DATA_WIDTH-1:0] ov_pix_data;
    logic                              o_sync_word_sel;
    logic                              o_hblk_n;
    modport master (output i_vd, i_hd, iv_pix_data, input ov_pix_data, o_sync_word_sel, o_hblk_n);
    modport slave (input i_vd, i_hd, iv_pix_data, output ov_pix_data, o_sync_word_sel, o_hblk_n);
endinterface

// File: rtl/ad_sync_framer.sv
// ad_sync_framer: frames raw ADC samples into output lines with sync words and blanking.
// Define AD_SYNC_FRAMER_LINE_CRC_EN to emit a CRC-16-CCITT word at the blanking start.
module ad_sync_framer #(
    parameter int ADC_WIDTH     = 14,
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNEL_NUM   = 2,
    parameter int SYNC_WORD_NUM = 7,
    parameter int CNT_WIDTH     = 13
) (
    input  logic                                clk,
    input  logic                                reset_n,
    ad_sync_framer_if.slave                     vid,
    input  logic                                i_lvds_pattern_en,
    input  logic [DATA_WIDTH-1:0]               iv_lvds_pattern,
    input  logic                                i_sync_align_loc,
    input  logic [CNT_WIDTH-1:0]                iv_sync_start_loc,
    input  logic [SYNC_WORD_NUM*DATA_WIDTH-1:0] iv_sync_word,
    input  logic [CNT_WIDTH-1:0]                iv_hblk_tog1,
    input  logic [CNT_WIDTH-1:0]                iv_hblk_tog2
);
    typedef enum logic [1:0] {IDLE, PIX, SYNC, CRC} state_t;
    state_t state, nxt_state;
    logic hd_q, rise, align_r, in_sync, nxt_sel, nxt_hblk;
    logic [CNT_WIDTH-1:0] cnt, start_r, tog1_r, tog2_r, widx;
    logic [SYNC_WORD_NUM*DATA_WIDTH-1:0] words_r;
    logic [CHANNEL_NUM*ADC_WIDTH-1:0] pix_q;
    logic [CHANNEL_NUM*DATA_WIDTH-1:0] fmt, nxt_word;
    logic [DATA_WIDTH-1:0] sw;
    assign rise    = vid.i_hd & ~hd_q;
    assign widx    = cnt - start_r;
    assign in_sync = (widx < CNT_WIDTH'(SYNC_WORD_NUM)) && (state == SYNC || cnt == start_r);
    // Formatting happens at the output stage so a new line's alignment applies from its first pixel.
    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_fmt
        logic [DATA_WIDTH-1:0] ext;
        assign ext = DATA_WIDTH'(pix_q[c*ADC_WIDTH +: ADC_WIDTH]);
        assign fmt[c*DATA_WIDTH +: DATA_WIDTH] = align_r ? ext << (DATA_WIDTH - ADC_WIDTH) : ext;
    end
    always_comb begin
        sw = '0;
        for (int k = 0; k < SYNC_WORD_NUM; k++)
            if (widx == CNT_WIDTH'(k)) sw = words_r[k*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef AD_SYNC_FRAMER_LINE_CRC_EN
    logic [15:0] crc;
    logic crc_acc, crc_win;
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DATA_WIDTH-1:0] d);
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
    assign crc_win = ({1'b0, cnt} >= {1'b0, start_r} + (CNT_WIDTH+1)'(SYNC_WORD_NUM)) && cnt < tog1_r;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) crc <= 16'hFFFF;
        else if (rise || nxt_state == CRC) crc <= 16'hFFFF;
        else if (crc_acc) crc <= crc_step(crc, fmt[DATA_WIDTH-1:0]);
`endif
    // A line-sync edge restarts the line ahead of every other event, including a drop of i_vd.
    always_comb begin
        nxt_state = state;
        nxt_word  = fmt;
        nxt_sel   = 1'b0;
        nxt_hblk  = 1'b1;
`ifdef AD_SYNC_FRAMER_LINE_CRC_EN
        crc_acc   = 1'b0;
`endif
        if (rise && (state != IDLE || vid.i_vd)) nxt_state = PIX;
        else if (!vid.i_vd || state == IDLE) nxt_state = IDLE;
        else begin
            nxt_hblk = !(cnt >= tog1_r && cnt < tog2_r);
            if (in_sync) begin
                nxt_state = SYNC;
                nxt_word  = {CHANNEL_NUM{sw}};
                nxt_sel   = 1'b1;
            end
`ifdef AD_SYNC_FRAMER_LINE_CRC_EN
            else if (cnt == tog1_r) begin
                nxt_state = CRC;
                nxt_word  = {CHANNEL_NUM{DATA_WIDTH'(crc)}};
                nxt_sel   = 1'b1;
            end else begin
                nxt_state = PIX;
                crc_acc   = crc_win;
            end
`else
            else nxt_state = PIX;
`endif
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            hd_q                <= 1'b0;
            cnt                 <= '0;
            pix_q               <= '0;
            align_r             <= 1'b0;
            start_r             <= '0;
            tog1_r              <= '0;
            tog2_r              <= '0;
            words_r             <= '0;
            vid.ov_pix_data     <= '0;
            vid.o_sync_word_sel <= 1'b0;
            vid.o_hblk_n        <= 1'b1;
        end else begin
            state <= nxt_state;
            hd_q  <= vid.i_hd;
            cnt   <= rise ? '0 : (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
            pix_q <= vid.iv_pix_data;
            if (rise) begin
                align_r <= i_sync_align_loc;
                start_r <= iv_sync_start_loc;
                tog1_r  <= iv_hblk_tog1;
                tog2_r  <= iv_hblk_tog2;
                words_r <= iv_sync_word;
            end
            vid.ov_pix_data     <= i_lvds_pattern_en ? {CHANNEL_NUM{iv_lvds_pattern}} : nxt_word;
            vid.o_sync_word_sel <= nxt_sel && !i_lvds_pattern_en;
            vid.o_hblk_n        <= nxt_hblk;
        end
    end
endmodule

// File: tb/tb_ad_sync_framer.sv
// tb_ad_sync_framer: directed line scenarios checked against a position-based line model.
// The model also covers the AD_SYNC_FRAMER_LINE_CRC_EN build.
module tb_ad_sync_framer;
    localparam int AW = 14, DW = 16, CN = 2, SWN = 7, CW = 13;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic reset_n;
    logic pat_en, align;
    logic [DW-1:0] pat;
    logic [CW-1:0] start, tog1, tog2;
    logic [SWN*DW-1:0] words;
    int n_chk = 0, n_fail = 0, nz;
    ad_sync_framer_if #(.ADC_WIDTH(AW), .DATA_WIDTH(DW), .CHANNEL_NUM(CN)) vid ();
    ad_sync_framer #(.ADC_WIDTH(AW), .DATA_WIDTH(DW), .CHANNEL_NUM(CN), .SYNC_WORD_NUM(SWN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .vid(vid),
        .i_lvds_pattern_en(pat_en), .iv_lvds_pattern(pat), .i_sync_align_loc(align),
        .iv_sync_start_loc(start), .iv_sync_word(words), .iv_hblk_tog1(tog1), .iv_hblk_tog2(tog2)
    );
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each output slot carries the pixel at a line position, replaced by sync/CRC words by position rules.
    bit m_act, m_hdq, m_align, m_rise;
    int m_pos, m_start, m_t1, m_t2;
    logic [CN*AW-1:0] m_prev;
    logic [SWN*DW-1:0] m_words;
    logic [15:0] m_crc;
    logic [CN*DW-1:0] m_fw, e_pix = '0;
    logic e_sel = 1'b0, e_hblk = 1'b1;

    function automatic logic [CN*DW-1:0] fmt_all(input logic [CN*AW-1:0] p, input bit a);
        logic [CN*DW-1:0] r;
        int s;
        for (int c = 0; c < CN; c++) begin
            s = int'(p[c*AW +: AW]);
            r[c*DW +: DW] = DW'(a ? s * 4 : s);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
        for (int i = 15; i >= 0; i--) c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_act = 0; m_hdq = 0; m_align = 0; m_pos = 0; m_start = 0; m_t1 = 0; m_t2 = 0;
            m_prev = '0; m_words = '0; m_crc = 16'hFFFF;
            e_pix = '0; e_sel = 1'b0; e_hblk = 1'b1;
        end else begin
            m_rise = vid.i_hd && !m_hdq;
            m_fw = fmt_all(m_prev, m_align);
            e_pix = m_fw; e_sel = 1'b0; e_hblk = 1'b1;
            if (m_rise && (m_act || vid.i_vd)) m_act = 1;
            else if (!vid.i_vd || !m_act) m_act = 0;
            else begin
                e_hblk = !(m_pos >= m_t1 && m_pos < m_t2);
                if (m_pos >= m_start && m_pos < m_start + SWN) begin
                    e_sel = 1'b1;
                    e_pix = {CN{m_words[(m_pos - m_start)*DW +: DW]}};
                end
`ifdef AD_SYNC_FRAMER_LINE_CRC_EN
                else if (m_pos == m_t1) begin
                    e_sel = 1'b1;
                    e_pix = {CN{m_crc}};
                    m_crc = 16'hFFFF;
                end else if (m_pos >= m_start + SWN && m_pos < m_t1) m_crc = crc16(m_crc, m_fw[DW-1:0]);
`endif
            end
            if (pat_en) begin e_pix = {CN{pat}}; e_sel = 1'b0; end
            if (m_rise) begin
                m_align = align; m_start = int'(start); m_t1 = int'(tog1); m_t2 = int'(tog2);
                m_words = words; m_crc = 16'hFFFF;
            end
            m_pos = m_rise ? 0 : (m_pos < CMAX ? m_pos + 1 : CMAX);
            m_hdq = vid.i_hd;
            m_prev = vid.iv_pix_data;
        end
    end

    initial forever begin
        @(negedge clk);
        check("ov_pix_data", vid.ov_pix_data, e_pix);
        check("o_sync_word_sel", vid.o_sync_word_sel, e_sel);
        check("o_hblk_n", vid.o_hblk_n, e_hblk);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the slot just before line position 0.
    task automatic line_start();
        vid.i_hd = 1'b1;
        step(1);
        vid.i_hd = 1'b0;
    endtask

    task automatic sync_seq();
        step(4);
        check("pre_sync_sel", vid.o_sync_word_sel, 0);
        for (int k = 0; k < SWN; k++) begin
            step(1);
            check("sync_word", vid.ov_pix_data, {CN{16'hFF00 + 16'(k)}});
            check("sync_sel", vid.o_sync_word_sel, 1);
        end
        step(1);
        check("post_sync_sel", vid.o_sync_word_sel, 0);
    endtask

    initial begin
        reset_n = 1'b0; vid.i_vd = 1'b0; vid.i_hd = 1'b0; vid.iv_pix_data = '0;
        pat_en = 1'b0; pat = 16'h5A5A; align = 1'b0; start = 4; tog1 = 20; tog2 = 30;
        for (int k = 0; k < SWN; k++) words[k*DW +: DW] = 16'hFF00 + 16'(k);
        step(3);
        check("reset_ov", vid.ov_pix_data, 0);
        check("reset_sel", vid.o_sync_word_sel, 0);
        check("reset_hblk", vid.o_hblk_n, 1);
        reset_n = 1'b1;
        vid.iv_pix_data = {14'h0123, 14'h3ABC};
        vid.i_vd = 1'b1;
        step(2);
        line_start();
        sync_seq();
        check("fmt_right", vid.ov_pix_data, 32'h0123_3ABC);
        nz = 0;
        for (int i = 0; i < 34; i++) begin step(1); if (!vid.o_hblk_n) nz++; end
        check("hblk_width", nz, 10);
        align = 1'b1; tog1 = 30; tog2 = 20;
        line_start();
        step(3);
        check("fmt_left", vid.ov_pix_data, 32'h048C_EAF0);
        nz = 0;
        for (int i = 0; i < 40; i++) begin step(1); if (!vid.o_hblk_n) nz++; end
        check("hblk_inverted", nz, 0);
        align = 1'b0; tog1 = 20; tog2 = 30;
        line_start();
        step(5);
        check("abort_w0", vid.ov_pix_data, 32'hFF00_FF00);
        step(2);
        check("abort_w2", vid.ov_pix_data, 32'hFF02_FF02);
        line_start();
        check("abort_sel", vid.o_sync_word_sel, 0);
        sync_seq();
        pat_en = 1'b1;
        line_start();
        for (int i = 0; i < 14; i++) begin
            step(1);
            check("pattern_ov", vid.ov_pix_data, 32'h5A5A_5A5A);
            check("pattern_sel", vid.o_sync_word_sel, 0);
        end
        pat_en = 1'b0; tog1 = 11;
        line_start();
        step(12);
`ifdef AD_SYNC_FRAMER_LINE_CRC_EN
        check("crc_word", vid.ov_pix_data, 32'hFFFF_FFFF);
        check("crc_sel", vid.o_sync_word_sel, 1);
`else
        check("tog1_pixel", vid.ov_pix_data, 32'h0123_3ABC);
        check("tog1_sel", vid.o_sync_word_sel, 0);
`endif
        step(5);
        check("pre_reset_hblk", vid.o_hblk_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ov", vid.ov_pix_data, 0);
        check("async_reset_sel", vid.o_sync_word_sel, 0);
        check("async_reset_hblk", vid.o_hblk_n, 1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_sel", vid.o_sync_word_sel, 0);
            check("idle_hblk", vid.o_hblk_n, 1);
        end
        tog1 = 12;
        line_start();
        sync_seq();
        vid.i_vd = 1'b0;
        step(1);
        check("vd_drop_hblk", vid.o_hblk_n, 1);
        check("vd_drop_ov", vid.ov_pix_data, 32'h0123_3ABC);
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_sync_framer.md
AD_SYNC_FRAMER -- requirements
Module: ad_sync_framer

Interface
REQ-001 Parameter ADC_WIDTH, default 14: ADC sample width per channel.
REQ-002 Parameter DATA_WIDTH, default 16: output word width per channel; SHALL be >= ADC_WIDTH.
REQ-003 Parameter CHANNEL_NUM, default 2: number of parallel pixel channels.
REQ-004 Parameter SYNC_WORD_NUM, default 7: sync words per line, 1..15.
REQ-005 Parameter CNT_WIDTH, default 13: pixel counter and position-register width.
REQ-006 clk  input  1  pixel clock; the single clock domain.
REQ-007 reset_n  input  1  reset; asynchronous and active-low.
REQ-008 i_vd  input  1  frame valid; high enables line framing.
REQ-009 i_hd  input  1  line sync; a rising edge starts a line.
REQ-010 i_lvds_pattern_en  input  1  test-pattern override.
REQ-011 iv_lvds_pattern  input  DATA_WIDTH  test-pattern word.
REQ-012 i_sync_align_loc  input  1  sample alignment in the word: 0 = right (LSB), 1 = left (MSB).
REQ-013 iv_sync_start_loc  input  CNT_WIDTH  counter value of the first sync word.
REQ-014 iv_sync_word  input  SYNC_WORD_NUM*DATA_WIDTH  sync words; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 iv_hblk_tog1 / iv_hblk_tog2  input  CNT_WIDTH each  blanking start and end positions.
REQ-016 iv_pix_data  input  CHANNEL_NUM*ADC_WIDTH  raw samples; channel c occupies [c*ADC_WIDTH +: ADC_WIDTH].
REQ-017 ov_pix_data  output  CHANNEL_NUM*DATA_WIDTH  framed output words.
REQ-018 o_sync_word_sel  output  1  high while ov_pix_data carries sync (or CRC) words.
REQ-019 o_hblk_n  output  1  horizontal blanking, active-low.

Function
REQ-020 Counter: cnt SHALL load 0 on the cycle after an i_hd rising edge, increment each clk otherwise, and saturate at all-ones (no wrap).
REQ-021 FSM states: IDLE, PIX, SYNC, CRC. Transitions:
- IDLE->PIX on an i_hd rising edge with i_vd=1.
- PIX->SYNC when cnt==iv_sync_start_loc.
- SYNC->PIX after SYNC_WORD_NUM cycles.
- PIX->CRC when cnt==iv_hblk_tog1 (macro builds only); CRC->PIX after 1 cycle.
- Any state->IDLE on the cycle after i_vd=0.
REQ-022 An i_hd rising edge in any non-IDLE state SHALL restart the line (cnt=0, state PIX) and abort any sync sequence in progress; it wins over every simultaneous event.
REQ-023 Format: each sample SHALL be zero-extended into DATA_WIDTH, placed in the LSBs when i_sync_align_loc=0 and in the MSBs (zero LSBs) when 1.
REQ-024 SYNC state: on the cycle when cnt==iv_sync_start_loc+k, all channels SHALL output sync word k, with o_sync_word_sel=1.
REQ-025 o_hblk_n SHALL be 0 while iv_hblk_tog1 <= cnt < iv_hblk_tog2 in a non-IDLE state, otherwise 1; if tog1 >= tog2 it SHALL stay 1.
REQ-026 When i_lvds_pattern_en=1, all channels SHALL output iv_lvds_pattern with o_sync_word_sel=0, overriding pixel, sync and CRC words; o_hblk_n is unaffected.
REQ-027 In IDLE: formatted pixel data passes through, o_sync_word_sel=0, o_hblk_n=1.
REQ-028 Latency: ov_pix_data at cycle t SHALL derive from iv_pix_data at t-2; o_sync_word_sel and o_hblk_n SHALL be aligned to the same output cycle.
REQ-029 Configuration registers SHALL be sampled on the i_hd rising edge and held constant for the rest of the line.

Reset
REQ-030 While reset_n=0: ov_pix_data=0, o_sync_word_sel=0, o_hblk_n=1, cnt=0, state IDLE, CRC register=0xFFFF, pipeline cleared.
REQ-031 A reset asserted mid-line SHALL take effect immediately (asynchronously); after release the block SHALL wait in IDLE for the next i_hd rising edge.

Configuration
REQ-032 Macro AD_SYNC_FRAMER_LINE_CRC_EN defined, CRC accumulation:
- CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, MSB first) accumulates over channel-0 formatted PIX words from cnt==iv_sync_start_loc+SYNC_WORD_NUM to iv_hblk_tog1-1.
- In CRC state, all channels output the CRC with o_sync_word_sel=1, then the CRC register re-initialises to 0xFFFF.
REQ-033 Macro AD_SYNC_FRAMER_LINE_CRC_EN undefined: no CRC state or logic; the cycle at cnt==iv_hblk_tog1 carries normal pixel data.

Verification
REQ-034 Setup: start_loc=4, SYNC_WORD_NUM=7, sync words 0xFF00..0xFF06, pattern off. Pulse i_hd with i_vd=1. Required: ov shows 0xFF00..0xFF06 on both channels on 7 consecutive cycles, with o_sync_word_sel=1 on exactly those cycles.
REQ-035 Input sample 0x3ABC. Required: ov=0x3ABC with align=0; ov=0xEAF0 with align=1.
REQ-036 tog1=20, tog2=30. Required: o_hblk_n=0 for exactly 10 cycles; with tog1=30, tog2=20, o_hblk_n stays 1.
REQ-037 i_hd rising edge during sync word 3. Required: sequence aborts, cnt restarts at 0, and the full 7-word sequence reappears at the next start_loc.
REQ-038 Pattern 0x5A5A enabled throughout a line. Required: ov=0x5A5A on all channels every cycle, o_sync_word_sel=0.
REQ-039 Macro defined, start_loc=4, tog1=11 (zero-length CRC window). Required: the CRC word equals 0xFFFF with o_sync_word_sel=1; reset_n pulsed low mid-line returns all outputs to reset values immediately.
